// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM states, parity-type codes and DATA_W limits for the UART TX engine
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} uart_state_e;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD = 1'b1;
  localparam int DATA_W_MIN = 5;
  localparam int DATA_W_MAX = 9;
endpackage

// File: rtl/uart_tx_engine_if.sv
// uart_tx_engine_if: host-side handshake, frame options and line outputs of the UART TX engine
interface uart_tx_engine_if #(parameter int DATA_W = 8);
  logic transmit;
  logic [DATA_W-1:0] TX_DATA;
  logic par_EN;
  logic par_TYP;
  logic stop2;
  logic ready;
  logic busy;
  logic done;
  logic TX_OUT;
  modport master (output transmit, TX_DATA, par_EN, par_TYP, stop2, input ready, busy, done, TX_OUT);
  modport slave (input transmit, TX_DATA, par_EN, par_TYP, stop2, output ready, busy, done, TX_OUT);
endinterface

// File: rtl/uart_tx_parity.sv
// uart_tx_parity: reduction-XOR parity with even/odd select
module uart_tx_parity
  import uart_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  input  logic              typ,
  output logic              p
);
  assign p = (typ == PAR_ODD) ? ~^data : ^data;
endmodule

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: tick-paced UART serialiser (start, DATA_W bits LSB first, parity, 1/2 stop bits)
// Parity support is built only when UART_TX_PARITY_EN is defined.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input logic CLK,
  input logic RST,
  input logic TX_tick,
  uart_tx_engine_if.slave bus
);
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
  uart_state_e state_q, state_d;
  logic pend_q, pend_d, stop2_q, stop2_d, par_en_q, par_en_d, par_q, par_d;
  logic tx_q, tx_d, busy_q, busy_d, done_q, done_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic accept, par_bit, par_en_in;
  assign bus.ready = (state_q == IDLE) && !pend_q;
  assign accept = bus.transmit && bus.ready;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.TX_OUT = tx_q;
`ifdef UART_TX_PARITY_EN
  uart_tx_parity #(.DATA_W(DATA_W)) u_parity (.data(bus.TX_DATA), .typ(bus.par_TYP), .p(par_bit));
  assign par_en_in = bus.par_EN;
`else
  logic unused_par;
  assign unused_par = bus.par_EN ^ bus.par_TYP;
  assign par_bit = 1'b0;
  assign par_en_in = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    pend_d = pend_q | accept;
    shift_d = accept ? bus.TX_DATA : shift_q;
    cnt_d = cnt_q;
    done_d = 1'b0;
    par_en_d = accept ? par_en_in : par_en_q;
    par_d = accept ? par_bit : par_q;
    stop2_d = accept ? bus.stop2 : stop2_q;
    case (state_q)
      IDLE: if (TX_tick && pend_q) begin
        state_d = START;
        pend_d = 1'b0;
      end
      START: if (TX_tick) begin
        state_d = DATA;
        cnt_d = '0;
      end
      DATA: if (TX_tick) begin
        if (cnt_q == LAST) state_d = par_en_q ? PARITY : STOP1;
        else begin
          cnt_d = cnt_q + 1'b1;
          shift_d = shift_q >> 1;
        end
      end
      PARITY: if (TX_tick) state_d = STOP1;
      STOP1: if (TX_tick) begin
        state_d = stop2_q ? STOP2 : IDLE;
        done_d = !stop2_q;
      end
      STOP2: if (TX_tick) begin
        state_d = IDLE;
        done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = pend_d || (state_d != IDLE);
    // line value is registered for the state being entered, so it moves on the tick edge
    tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : (state_d == PARITY) ? par_q : 1'b1;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      pend_q <= 1'b0;
      shift_q <= '0;
      cnt_q <= '0;
      par_en_q <= 1'b0;
      par_q <= 1'b0;
      stop2_q <= 1'b0;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      shift_q <= shift_d;
      cnt_q <= cnt_d;
      par_en_q <= par_en_d;
      par_q <= par_d;
      stop2_q <= stop2_d;
      tx_q <= tx_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: scoreboard bench; queued expected frames are compared bit by bit on each tick
module tb_uart_tx_engine;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif
  typedef struct {
    logic [15:0] bits;
    int len;
  } frame_t;
  logic clk, rst, tick;
  int tc = 0;
  int checks = 0;
  int errors = 0;
  frame_t frames[$];
  frame_t cur;
  bit in_frame = 0;
  int idx = 0;
  int tick_n = 0;
  int start_tick = 0;
  int done_tick = 0;
  logic tk, rs, prev_tx, end_edge;
  uart_tx_engine_if #(.DATA_W(8)) u_if ();
  uart_tx_engine_if #(.DATA_W(5)) u_if5 ();
  uart_tx_engine #(.DATA_W(8)) dut (.CLK(clk), .RST(rst), .TX_tick(tick), .bus(u_if));
  uart_tx_engine #(.DATA_W(5)) dut5 (.CLK(clk), .RST(rst), .TX_tick(tick), .bus(u_if5));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tick = (tc == 3);
      tc = (tc + 1) % 4;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic frame_t mk(input int w, input logic [8:0] d, input bit pe, input bit pt, input bit s2);
    frame_t f;
    logic [8:0] m;
    int n;
    m = d & ((9'h1 << w) - 9'h1);
    f.bits = '1;
    f.bits[0] = 1'b0;
    for (int i = 0; i < w; i++) f.bits[1+i] = d[i];
    n = 1 + w;
    if (pe && PAR_BUILD) begin
      f.bits[n] = pt ? ~^m : ^m;
      n++;
    end
    f.len = n + (s2 ? 2 : 1);
    return f;
  endfunction
  always @(posedge clk) begin
    tk = tick;
    rs = rst;
    #1;
    if (rs) begin
      frames.delete();
      in_frame = 0;
    end else begin
      end_edge = tk && in_frame && (idx == cur.len);
      check("done", u_if.done, end_edge);
      if (!tk) check("tx_hold", u_if.TX_OUT, prev_tx);
      else if (end_edge) begin
        check("tx_idle_after_stop", u_if.TX_OUT, 1);
        in_frame = 0;
        done_tick = tick_n;
      end else if (in_frame) begin
        check("tx_bit", u_if.TX_OUT, cur.bits[idx]);
        idx++;
      end else if (!u_if.TX_OUT) begin
        if (frames.size() == 0) check("spurious_start", frames.size(), 1);
        else begin
          cur = frames.pop_front();
          idx = 1;
          in_frame = 1;
          start_tick = tick_n;
        end
      end
      if (tk) tick_n++;
    end
    prev_tx = u_if.TX_OUT;
  end
  task automatic send(input logic [8:0] d, input bit pe, input bit pt, input bit s2, input bit hold);
    int n = 0;
    @(negedge clk);
    u_if.TX_DATA = d[7:0];
    u_if.par_EN = pe;
    u_if.par_TYP = pt;
    u_if.stop2 = s2;
    u_if.transmit = 1'b1;
    while (!u_if.ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("accept_timeout", n, 0);
    else begin
      frames.push_back(mk(8, d, pe, pt, s2));
      @(posedge clk);
      #1;
      check("busy_after_accept", u_if.busy, 1);
      check("ready_after_accept", u_if.ready, 0);
      if (!hold) u_if.transmit = 1'b0;
    end
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((frames.size() != 0 || in_frame) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("idle_timeout", n, 0);
    else begin
      @(negedge clk);
      check("busy_idle", u_if.busy, 0);
      check("ready_idle", u_if.ready, 1);
    end
  endtask
  task automatic wait_tick();
    @(posedge clk);
    while (!tick) @(posedge clk);
    #1;
  endtask
  task automatic send5(input logic [4:0] d);
    frame_t f;
    int n = 0;
    f = mk(5, {4'b0, d}, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    u_if5.TX_DATA = d;
    u_if5.transmit = 1'b1;
    while (!u_if5.ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    u_if5.transmit = 1'b0;
    n = 0;
    do begin
      wait_tick();
      n++;
    end while (u_if5.TX_OUT && n < 8);
    check("w5_start", u_if5.TX_OUT, 0);
    for (int i = 1; i < f.len; i++) begin
      wait_tick();
      check("w5_bit", u_if5.TX_OUT, f.bits[i]);
    end
    wait_tick();
    check("w5_done", u_if5.done, 1);
    check("w5_idle", u_if5.TX_OUT, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end
  initial begin
    int n;
    int d1;
    rst = 1'b1;
    u_if.transmit = 1'b0;
    u_if.TX_DATA = '0;
    u_if.par_EN = 1'b0;
    u_if.par_TYP = 1'b0;
    u_if.stop2 = 1'b0;
    u_if5.transmit = 1'b0;
    u_if5.TX_DATA = '0;
    u_if5.par_EN = 1'b0;
    u_if5.par_TYP = 1'b0;
    u_if5.stop2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", u_if.TX_OUT, 1);
    check("rst_busy", u_if.busy, 0);
    check("rst_done", u_if.done, 0);
    check("rst_ready", u_if.ready, 1);
    @(negedge clk);
    rst = 1'b0;
    send(9'hA5, 1, 0, 0, 0);
    wait_idle();
    send(9'hA5, 1, 1, 1, 0);
    wait_idle();
    send(9'h00, 0, 0, 0, 1);
    send(9'hFF, 0, 0, 0, 0);
    d1 = done_tick;
    wait_idle();
    check("b2b_start_after_done", start_tick - d1, 1);
    send(9'h3C, 0, 0, 0, 0);
    n = 0;
    while (!(in_frame && idx >= 4) && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_tx", u_if.TX_OUT, 1);
    check("midrst_busy", u_if.busy, 0);
    check("midrst_done", u_if.done, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    send(9'h3C, 0, 0, 0, 0);
    wait_idle();
    send(9'hA5, 0, 0, 0, 0);
    @(negedge clk);
    u_if.par_EN = 1'b1;
    u_if.par_TYP = 1'b1;
    u_if.stop2 = 1'b1;
    wait_idle();
    send(9'h5A, 1, 0, 0, 0);
    wait_idle();
    send5(5'h15);
    for (int k = 0; k < 4; k++) begin
      send(9'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 0);
      wait_idle();
    end
    check("queue_drained", frames.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
